cardinal_nic_driver: RTL and testbench
======================================

CARDINAL_NIC_DRIVER -- requirements
Module: cardinal_nic_driver

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle run request, sampled only in IDLE.
REQ-004 SHALL have port tx_count, input, [0:7], number of packets to send, latched on start.
REQ-005 SHALL have port rx_expect, input, [0:7], number of packets to receive, latched on start.
REQ-006 SHALL have port tx_hdr, input, [0:31], upper packet word (bits 0:31), latched on start.
REQ-007 SHALL have port tx_seed, input, [0:31], first payload value, latched on start.
REQ-008 SHALL have port addr_nic, output, [0:1], NIC register select.
REQ-009 SHALL have port din_nic, output, [0:63], write data to the NIC.
REQ-010 SHALL have port dout_nic, input, [0:63], read data from the NIC, valid combinationally in the request cycle.
REQ-011 SHALL have ports nicEn and nicWrEn, outputs, 1 each, NIC access enable and write enable.
REQ-012 SHALL have ports busy and done, outputs, 1 each, run in progress and run finished.
REQ-013 SHALL have ports tx_sent and rx_count, outputs, [0:7] each, packets sent and received this run.
REQ-014 SHALL have ports rx_last [0:63] and rx_sum [0:31], outputs, last received packet and XOR of received payloads (bits 32:63).
REQ-015 SHALL have port timeout_err, output, 1, set when the run aborts on timeout.

Function
REQ-016 NIC map SHALL be: 00 input buffer (read), 01 input status, 10 output buffer (write), 11 output status; status full flag is dout_nic[63].
REQ-017 Exactly one NIC access per cycle in every state except IDLE and DONE; nicEn=0 and nicWrEn=0 in IDLE and DONE.
REQ-018 IDLE: on start=1, latch inputs, clear tx_sent, rx_count, rx_sum, rx_last, timeout_err and done, then go to RX_POLL.
REQ-019 RX_POLL: read addr 01; if rx_count==rx_expect and tx_sent==tx_count, go to DONE without issuing the read; else if dout_nic[63]=1 and rx_count<rx_expect, go to RECV; else go to TX_POLL if tx_sent<tx_count, otherwise stay in RX_POLL.
REQ-020 RECV: read addr 00; capture dout_nic into rx_last, XOR dout_nic[32:63] into rx_sum, increment rx_count, go to RX_POLL.
REQ-021 TX_POLL: read addr 11; if dout_nic[63]=0 go to SEND, else go to RX_POLL.
REQ-022 SEND: write addr 10, din_nic={tx_hdr, tx_seed+tx_sent} (32-bit sum, modulo 2^32), nicWrEn=1, increment tx_sent, go to RX_POLL.
REQ-023 din_nic SHALL be 0 whenever nicWrEn=0.
REQ-024 DONE: done=1, busy=0; counters and results hold; start=1 re-enters the IDLE start action the same cycle.
REQ-025 busy SHALL be 1 in RX_POLL, RECV, TX_POLL and SEND.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 tx_count=0 and rx_expect=0 SHALL reach DONE two cycles after start with no NIC access.
REQ-028 Counters SHALL never exceed their latched targets; no wrap is possible.

Reset
REQ-029 While reset=0: state IDLE, all outputs 0, all latched inputs 0, immediately and regardless of clk.
REQ-030 Reset asserted mid-run SHALL abort the access in progress, and nicEn SHALL drop combinationally.

Configuration
REQ-031 With NIC_DRV_TIMEOUT_EN defined: a 16-bit idle counter resets on each RECV or SEND and increments in other busy cycles; at 65535 it SHALL set timeout_err=1 and go to DONE.
REQ-032 Without NIC_DRV_TIMEOUT_EN: no counter is instantiated, timeout_err is tied to 0, and runs wait indefinitely.

Verification
REQ-033 Loopback NIC model, tx_count=4, rx_expect=4, tx_hdr=0x0001_0000, tx_seed=0x10 -> payloads 0x10..0x13 written, rx_count=4, rx_sum=0x00000000, done=1.
REQ-034 Output status held full for 20 cycles, tx_count=1 -> only reads of addr 11/01 during the hold, then one write, tx_sent=1.
REQ-035 tx_count=0, rx_expect=0, start pulse -> done=1 two cycles later, nicEn never asserted.
REQ-036 reset=0 during SEND -> nicEn=0, nicWrEn=0 and all outputs 0 within the same cycle, state IDLE after release.
REQ-037 With the macro defined, rx_expect=1 and input status never full -> timeout_err=1 and done=1 after 65535 idle busy cycles; without the macro, still busy.
REQ-038 start pulsed while busy -> latched targets unchanged, run completes with the original counts.

Source files
------------

// File: rtl/cardinal_nic_driver_if.sv
// NIC register-port bundle: the driver is the master, the NIC (or its model) is the slave.
interface cardinal_nic_driver_if;
    logic [0:1]  addr_nic;
    logic [0:63] din_nic;
    logic [0:63] dout_nic;
    logic        nicEn;
    logic        nicWrEn;

    modport master (
        output addr_nic,
        output din_nic,
        output nicEn,
        output nicWrEn,
        input  dout_nic
    );

    modport slave (
        input  addr_nic,
        input  din_nic,
        input  nicEn,
        input  nicWrEn,
        output dout_nic
    );
endinterface

// File: rtl/cardinal_nic_driver.sv
// Polled NIC driver: interleaves sending tx_count packets and receiving rx_expect packets.
// Optional idle-timeout abort is compiled in with `define NIC_DRV_TIMEOUT_EN.
module cardinal_nic_driver (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [0:7]             tx_count,
    input  logic [0:7]             rx_expect,
    input  logic [0:31]            tx_hdr,
    input  logic [0:31]            tx_seed,
    cardinal_nic_driver_if.master  nic,
    output logic                   busy,
    output logic                   done,
    output logic [0:7]             tx_sent,
    output logic [0:7]             rx_count,
    output logic [0:63]            rx_last,
    output logic [0:31]            rx_sum,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_POLL = 3'd1,
        S_RECV    = 3'd2,
        S_TX_POLL = 3'd3,
        S_SEND    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [0:7]  r_tx_count;
    logic [0:7]  r_rx_expect;
    logic [0:31] r_tx_hdr;
    logic [0:31] r_tx_seed;
    logic [0:7]  r_tx_sent;
    logic [0:7]  r_rx_count;
    logic [0:63] r_rx_last;
    logic [0:31] r_rx_sum;
    logic        r_busy;
    logic        r_done;

    logic        w_start_run;
    logic        w_all_done;
    logic        w_rx_more;
    logic        w_tx_more;
    logic        w_status_full;
    logic        w_timeout_hit;

    logic [0:1]  w_addr;
    logic [0:63] w_din;
    logic        w_en;
    logic        w_wr_en;

    function automatic logic [0:31] payload_word(input logic [0:31] seed, input logic [0:7] idx);
        payload_word = seed + {24'd0, idx};
    endfunction

    assign w_start_run   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_all_done    = (r_rx_count == r_rx_expect) && (r_tx_sent == r_tx_count);
    assign w_rx_more     = (r_rx_count < r_rx_expect);
    assign w_tx_more     = (r_tx_sent < r_tx_count);
    assign w_status_full = nic.dout_nic[63];

`ifdef NIC_DRV_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
    logic        r_timeout_err;
    logic        w_idle_cycle;

    assign w_idle_cycle  = (r_state == S_RX_POLL) || (r_state == S_TX_POLL);
    // FFFE here means this is the 65535th consecutive idle busy cycle.
    assign w_timeout_hit = w_idle_cycle && (r_idle_cnt == 16'hFFFE);
    assign timeout_err   = r_timeout_err;

    // Idle counter: cleared by progress (RECV/SEND) or a new run, saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= 16'd0;
        end else if (w_start_run || (r_state == S_RECV) || (r_state == S_SEND)) begin
            r_idle_cnt <= 16'd0;
        end else if (w_idle_cycle && (r_idle_cnt != 16'hFFFF)) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    // Sticky abort flag, cleared only by a new run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_start_run) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout_hit && !w_all_done) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RX_POLL;
                else       w_next_state = S_IDLE;
            end
            S_RX_POLL: begin
                if (w_all_done)                      w_next_state = S_DONE;
                else if (w_timeout_hit)              w_next_state = S_DONE;
                else if (w_status_full && w_rx_more) w_next_state = S_RECV;
                else if (w_tx_more)                  w_next_state = S_TX_POLL;
                else                                 w_next_state = S_RX_POLL;
            end
            S_RECV: begin
                w_next_state = S_RX_POLL;
            end
            S_TX_POLL: begin
                if (w_timeout_hit)       w_next_state = S_DONE;
                else if (!w_status_full) w_next_state = S_SEND;
                else                     w_next_state = S_RX_POLL;
            end
            S_SEND: begin
                w_next_state = S_RX_POLL;
            end
            S_DONE: begin
                if (start) w_next_state = S_RX_POLL;
                else       w_next_state = S_DONE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NIC access decode; RX_POLL skips its read once both targets are met.
    always_comb begin
        w_addr  = 2'b00;
        w_din   = 64'd0;
        w_en    = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            S_RX_POLL: begin
                w_addr = 2'b01;
                w_en   = !w_all_done;
            end
            S_RECV: begin
                w_addr = 2'b00;
                w_en   = 1'b1;
            end
            S_TX_POLL: begin
                w_addr = 2'b11;
                w_en   = 1'b1;
            end
            S_SEND: begin
                w_addr  = 2'b10;
                w_en    = 1'b1;
                w_wr_en = 1'b1;
                w_din   = {r_tx_hdr, payload_word(r_tx_seed, r_tx_sent)};
            end
            default: begin
                w_addr = 2'b00;
            end
        endcase
    end

    // Gating with reset lets an abort cut the bus access without waiting for the flop.
    assign nic.addr_nic = reset ? w_addr : 2'b00;
    assign nic.nicEn    = w_en && reset;
    assign nic.nicWrEn  = w_wr_en && reset;
    assign nic.din_nic  = (w_wr_en && reset) ? w_din : 64'd0;

    // Run parameters and result accumulators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_count  <= 8'd0;
            r_rx_expect <= 8'd0;
            r_tx_hdr    <= 32'd0;
            r_tx_seed   <= 32'd0;
            r_tx_sent   <= 8'd0;
            r_rx_count  <= 8'd0;
            r_rx_last   <= 64'd0;
            r_rx_sum    <= 32'd0;
        end else if (w_start_run) begin
            r_tx_count  <= tx_count;
            r_rx_expect <= rx_expect;
            r_tx_hdr    <= tx_hdr;
            r_tx_seed   <= tx_seed;
            r_tx_sent   <= 8'd0;
            r_rx_count  <= 8'd0;
            r_rx_last   <= 64'd0;
            r_rx_sum    <= 32'd0;
        end else begin
            case (r_state)
                S_RECV: begin
                    r_rx_last  <= nic.dout_nic;
                    r_rx_sum   <= r_rx_sum ^ nic.dout_nic[32:63];
                    r_rx_count <= r_rx_count + 8'd1;
                end
                S_SEND: begin
                    r_tx_sent <= r_tx_sent + 8'd1;
                end
                default: begin
                    r_tx_sent <= r_tx_sent;
                end
            endcase
        end
    end

    // Status flags track the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_RX_POLL) || (w_next_state == S_RECV) ||
                      (w_next_state == S_TX_POLL) || (w_next_state == S_SEND);
            r_done <= (w_next_state == S_DONE);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_sent  = r_tx_sent;
    assign rx_count = r_rx_count;
    assign rx_last  = r_rx_last;
    assign rx_sum   = r_rx_sum;

endmodule

// File: tb/tb_cardinal_nic_driver.sv
// Directed bench for cardinal_nic_driver with a loopback NIC model.
module tb_cardinal_nic_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:7]  tx_count;
    logic [0:7]  rx_expect;
    logic [0:31] tx_hdr;
    logic [0:31] tx_seed;
    logic        busy;
    logic        done;
    logic [0:7]  tx_sent;
    logic [0:7]  rx_count;
    logic [0:63] rx_last;
    logic [0:31] rx_sum;
    logic        timeout_err;

    cardinal_nic_driver_if nic_if();

    cardinal_nic_driver dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tx_count   (tx_count),
        .rx_expect  (rx_expect),
        .tx_hdr     (tx_hdr),
        .tx_seed    (tx_seed),
        .nic        (nic_if.master),
        .busy       (busy),
        .done       (done),
        .tx_sent    (tx_sent),
        .rx_count   (rx_count),
        .rx_last    (rx_last),
        .rx_sum     (rx_sum),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Loopback NIC model: written packets reappear in the input buffer in order.
    logic        model_clr = 1'b1;
    logic        tx_full_hold = 1'b0;
    logic        hold_window = 1'b0;
    logic [0:63] fifo_mem [0:15];
    logic [0:63] wr_log   [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          wr_cnt = 0;
    int          en_cnt = 0;
    int          bad_hold_cnt = 0;
    int          din_leak_cnt = 0;

    always_comb begin
        nic_if.dout_nic = 64'd0;
        case (nic_if.addr_nic)
            2'b00:   nic_if.dout_nic = (wr_ptr != rd_ptr) ? fifo_mem[rd_ptr % 16] : 64'd0;
            2'b01:   nic_if.dout_nic = {63'd0, (wr_ptr != rd_ptr)};
            2'b11:   nic_if.dout_nic = {63'd0, tx_full_hold};
            default: nic_if.dout_nic = 64'd0;
        endcase
    end

    always @(posedge clk) begin
        if (model_clr) begin
            wr_ptr       <= 0;
            rd_ptr       <= 0;
            wr_cnt       <= 0;
            en_cnt       <= 0;
            bad_hold_cnt <= 0;
            din_leak_cnt <= 0;
        end else begin
            if (nic_if.nicEn) en_cnt <= en_cnt + 1;
            if (nic_if.nicEn && nic_if.nicWrEn && nic_if.addr_nic == 2'b10) begin
                fifo_mem[wr_ptr % 16] <= nic_if.din_nic;
                wr_log[wr_cnt % 16]   <= nic_if.din_nic;
                wr_ptr <= wr_ptr + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (nic_if.nicEn && !nic_if.nicWrEn && nic_if.addr_nic == 2'b00) rd_ptr <= rd_ptr + 1;
            if (hold_window && nic_if.nicEn && (nic_if.addr_nic == 2'b00 || nic_if.addr_nic == 2'b10))
                bad_hold_cnt <= bad_hold_cnt + 1;
            if (!nic_if.nicWrEn && nic_if.din_nic != 64'd0) din_leak_cnt <= din_leak_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] tc, input logic [7:0] re,
                             input logic [31:0] hdr, input logic [31:0] seed);
        tx_count  = tc;
        rx_expect = re;
        tx_hdr    = hdr;
        tx_seed   = seed;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (done) break;
            tick();
        end
        check({name, " done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"},   {63'd0, busy}, 64'd0);
        check({name, " done"},   {63'd0, done}, 64'd0);
        check({name, " tx_sent"}, {56'd0, tx_sent}, 64'd0);
        check({name, " rx_count"}, {56'd0, rx_count}, 64'd0);
        check({name, " rx_last"}, rx_last, 64'd0);
        check({name, " rx_sum"}, {32'd0, rx_sum}, 64'd0);
        check({name, " timeout_err"}, {63'd0, timeout_err}, 64'd0);
        check({name, " nicEn"},  {63'd0, nic_if.nicEn}, 64'd0);
        check({name, " nicWrEn"}, {63'd0, nic_if.nicWrEn}, 64'd0);
        check({name, " din_nic"}, nic_if.din_nic, 64'd0);
        check({name, " addr_nic"}, {62'd0, nic_if.addr_nic}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic [31:0] hdr;
        logic [31:0] seed;
        logic [31:0] exp_sum;
        logic [63:0] exp_last;
        logic [63:0] exp_last_wr;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        vecs[0] = '{8'd4, 8'd4, 32'h0001_0000, 32'h0000_0010, 32'h0000_0000,
                    64'h0001_0000_0000_0013, 64'h0001_0000_0000_0013};
        vecs[1] = '{8'd3, 8'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFE, 32'h0000_0001,
                    64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0000};
        vecs[2] = '{8'd2, 8'd0, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0000_0000,
                    64'h0000_0000_0000_0000, 64'hA5A5_A5A5_0000_0101};
        vecs[3] = '{8'd1, 8'd1, 32'h1234_5678, 32'h0000_00AA, 32'h0000_00AA,
                    64'h1234_5678_0000_00AA, 64'h1234_5678_0000_00AA};
        vecs[4] = '{8'd5, 8'd2, 32'h0000_0000, 32'h0000_0007, 32'h0000_000F,
                    64'h0000_0000_0000_0008, 64'h0000_0000_0000_000B};
        vecs[5] = '{8'd0, 8'd0, 32'h5555_5555, 32'h0000_0033, 32'h0000_0000,
                    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

        reset = 1'b1; start = 1'b0;
        tx_count = 8'd0; rx_expect = 8'd0; tx_hdr = 32'd0; tx_seed = 32'd0;
        #3 reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) tick();
        reset = 1'b1;
        clear_model();

        // Empty run: DONE two cycles after start, no NIC access.
        start_run(8'd0, 8'd0, 32'h0, 32'h0);
        check("empty c1 busy", {63'd0, busy}, 64'd1);
        check("empty c1 done", {63'd0, done}, 64'd0);
        check("empty c1 nicEn", {63'd0, nic_if.nicEn}, 64'd0);
        tick();
        check("empty c2 done", {63'd0, done}, 64'd1);
        check("empty c2 busy", {63'd0, busy}, 64'd0);
        check("empty en_cnt", en_cnt, 0);

        // Table: each run starts from DONE, exercising the restart path.
        for (int i = 0; i < 6; i++) begin
            clear_model();
            start_run(vecs[i].tx, vecs[i].rx, vecs[i].hdr, vecs[i].seed);
            check($sformatf("v%0d started done", i), {63'd0, done}, 64'd0);
            check($sformatf("v%0d started busy", i), {63'd0, busy}, 64'd1);
            wait_done($sformatf("v%0d", i), 300);
            check($sformatf("v%0d busy", i), {63'd0, busy}, 64'd0);
            check($sformatf("v%0d tx_sent", i), {56'd0, tx_sent}, {56'd0, vecs[i].tx});
            check($sformatf("v%0d rx_count", i), {56'd0, rx_count}, {56'd0, vecs[i].rx});
            check($sformatf("v%0d rx_sum", i), {32'd0, rx_sum}, {32'd0, vecs[i].exp_sum});
            check($sformatf("v%0d rx_last", i), rx_last, vecs[i].exp_last);
            check($sformatf("v%0d writes", i), wr_cnt, {24'd0, vecs[i].tx});
            check($sformatf("v%0d timeout", i), {63'd0, timeout_err}, 64'd0);
            check($sformatf("v%0d din leak", i), din_leak_cnt, 0);
            if (vecs[i].tx != 8'd0) begin
                check($sformatf("v%0d first wr", i), wr_log[0], {vecs[i].hdr, vecs[i].seed});
                check($sformatf("v%0d last wr", i), wr_log[(vecs[i].tx - 8'd1) % 16], vecs[i].exp_last_wr);
            end
        end

        // Output status held full for 20 cycles: only status polls, no write.
        clear_model();
        tx_full_hold = 1'b1;
        hold_window  = 1'b1;
        start_run(8'd1, 8'd0, 32'hCAFE_0000, 32'h0000_0005);
        repeat (19) tick();
        check("hold writes", wr_cnt, 0);
        check("hold tx_sent", {56'd0, tx_sent}, 64'd0);
        check("hold busy", {63'd0, busy}, 64'd1);
        check("hold bad addr", bad_hold_cnt, 0);
        hold_window  = 1'b0;
        tx_full_hold = 1'b0;
        wait_done("hold", 50);
        check("hold writes after", wr_cnt, 1);
        check("hold tx_sent after", {56'd0, tx_sent}, 64'd1);
        check("hold wr data", wr_log[0], 64'hCAFE_0000_0000_0005);

        // Start while busy is ignored.
        clear_model();
        start_run(8'd2, 8'd2, 32'h1111_0000, 32'h0000_0020);
        tick();
        start_run(8'd5, 8'd0, 32'hFFFF_FFFF, 32'h0);
        tick();
        start_run(8'd7, 8'd1, 32'h2222_2222, 32'h9);
        wait_done("busy start", 300);
        check("busy start tx_sent", {56'd0, tx_sent}, 64'd2);
        check("busy start rx_count", {56'd0, rx_count}, 64'd2);
        check("busy start rx_last", rx_last, 64'h1111_0000_0000_0021);
        check("busy start rx_sum", {32'd0, rx_sum}, 64'h0000_0000_0000_0001);
        check("busy start writes", wr_cnt, 2);

        // Receive never possible: timeout abort when enabled, otherwise waits forever.
        clear_model();
        start_run(8'd0, 8'd1, 32'h0, 32'h0);
`ifdef NIC_DRV_TIMEOUT_EN
        wait_done("timeout", 66000);
        check("timeout flag", {63'd0, timeout_err}, 64'd1);
        check("timeout busy", {63'd0, busy}, 64'd0);
        check("timeout rx_count", {56'd0, rx_count}, 64'd0);
`else
        repeat (300) tick();
        check("no timeout busy", {63'd0, busy}, 64'd1);
        check("no timeout done", {63'd0, done}, 64'd0);
        check("no timeout flag", {63'd0, timeout_err}, 64'd0);
`endif
        reset = 1'b0;
        #1 check_all_zero("reset hung");
        tick();
        reset = 1'b1;
        tick();

        // Reset during SEND aborts the write at once.
        clear_model();
        start_run(8'd1, 8'd0, 32'h0BAD_0000, 32'h0000_0001);
        for (int k = 0; k < 50; k++) begin
            if (nic_if.nicWrEn) break;
            tick();
        end
        check("send reached", {63'd0, nic_if.nicWrEn}, 64'd1);
        reset = 1'b0;
        #1 check_all_zero("reset in send");
        tick();
        check("aborted write", wr_cnt, 0);
        reset = 1'b1;
        tick();
        tick();
        check("post reset busy", {63'd0, busy}, 64'd0);
        check("post reset done", {63'd0, done}, 64'd0);
        check("post reset nicEn", {63'd0, nic_if.nicEn}, 64'd0);
        start_run(8'd1, 8'd1, 32'h0BAD_0000, 32'h0000_0001);
        wait_done("after reset run", 100);
        check("after reset rx_last", rx_last, 64'h0BAD_0000_0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
